// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline sequencer for the 5-stage CPU. It drives the load-use
//            stall, redirect flush and memory-latency freeze controls, and
//            keeps saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             redirect_i,
    input  logic             mem_req_i,
    output logic             pc_write_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam bit         c_HAS_WAIT = (MEM_LAT > 1);
    localparam int         c_LAT_M2   = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [3:0] c_LAT_INIT = 4'(c_LAT_M2);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_load_use;
    logic w_trigger;
    logic w_frozen;
    logic w_stall_applied;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (en && (v != {CNT_W{1'b1}})) ? (v + one) : v;
    endfunction

    always_comb begin
        w_load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((idex_rt_i == ifid_rs_i) ||
                      (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
        // The release cycle (WAIT, cnt==0) is the tail of the current access,
        // so mem_req_i there is not a new trigger.
        w_trigger  = c_HAS_WAIT && (state_q == ST_RUN) && mem_req_i;
        w_frozen   = w_trigger || ((state_q == ST_WAIT) && (cnt_q != 4'd0));
        w_stall_applied = rst_i && !w_frozen && w_load_use;
    end

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_hold_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i) begin
            if (w_frozen) begin
                freeze_o    = 1'b1;
                ifid_hold_o = 1'b1;
            end else if (w_load_use) begin
                // Branch operands are stale; the redirect re-resolves next cycle.
                ifid_hold_o   = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (redirect_i) begin
                pc_write_o   = 1'b1;
                ifid_flush_o = 1'b1;
            end else begin
                pc_write_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (w_trigger) begin
            state_d = ST_WAIT;
            cnt_d   = c_LAT_INIT;
        end else if (state_q == ST_WAIT) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = ST_RUN;
            end
        end
        stall_cnt_d  = sat_inc(stall_cnt_q, w_stall_applied);
        freeze_cnt_d = sat_inc(freeze_cnt_q, freeze_o);
        flush_cnt_d  = sat_inc(flush_cnt_q, ifid_flush_o);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_RUN;
            cnt_q        <= 4'd0;
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed plus randomized bench for pipe_hazard_ctrl against a
//            cycle-level behavioural model of the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             redirect_i;
    logic             mem_req_i;
    logic             pc_write_o;
    logic             ifid_hold_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             freeze_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] freeze_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .redirect_i     (redirect_i),
        .mem_req_i      (mem_req_i),
        .pc_write_o     (pc_write_o),
        .ifid_hold_o    (ifid_hold_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .freeze_o       (freeze_o),
        .stall_cnt_o    (stall_cnt_o),
        .freeze_cnt_o   (freeze_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: cycles left in the current memory access (0 = idle)
    int m_busy   = 0;
    int m_stall  = 0;
    int m_freeze = 0;
    int m_flush  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic u,
                        input logic rd, input logic mq);
        bit lu, frozen, trig;
        bit e_pc, e_hold, e_flush, e_bub, e_frz;
        @(negedge clk);
        rst_i = r; idex_memread_i = mr; idex_rt_i = xrt; ifid_rs_i = rs;
        ifid_rt_i = rt; ifid_uses_rt_i = u; redirect_i = rd; mem_req_i = mq;
        #1;
        lu     = mr && (xrt != 0) && ((xrt == rs) || (u && (xrt == rt)));
        trig   = (m_busy == 0) && mq && (MEM_LAT > 1);
        frozen = trig || (m_busy > 1);
        {e_pc, e_hold, e_flush, e_bub, e_frz} = 5'b0;
        if (r) begin
            if (frozen)  begin e_frz = 1; e_hold = 1; end
            else if (lu) begin e_hold = 1; e_bub = 1; end
            else if (rd) begin e_pc = 1; e_flush = 1; end
            else         e_pc = 1;
        end
        check("pc_write",    32'(pc_write_o),    32'(e_pc));
        check("ifid_hold",   32'(ifid_hold_o),   32'(e_hold));
        check("ifid_flush",  32'(ifid_flush_o),  32'(e_flush));
        check("idex_bubble", 32'(idex_bubble_o), 32'(e_bub));
        check("freeze",      32'(freeze_o),      32'(e_frz));
        check("hold_flush_excl", 32'(ifid_hold_o & ifid_flush_o), 32'd0);
        check("stall_cnt",   32'(stall_cnt_o),   32'(m_stall));
        check("freeze_cnt",  32'(freeze_cnt_o),  32'(m_freeze));
        check("flush_cnt",   32'(flush_cnt_o),   32'(m_flush));
        if (!r) begin
            m_busy = 0; m_stall = 0; m_freeze = 0; m_flush = 0;
        end else begin
            if (trig)            m_busy = MEM_LAT - 1;
            else if (m_busy > 0) m_busy = m_busy - 1;
            if (lu && !frozen && m_stall < CMAX) m_stall++;
            if (e_frz && m_freeze < CMAX)        m_freeze++;
            if (e_flush && m_flush < CMAX)       m_flush++;
        end
    endtask

    task automatic idle(input logic r);
        step(r, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 0; idex_memread_i = 0; idex_rt_i = 0; ifid_rs_i = 0;
        ifid_rt_i = 0; ifid_uses_rt_i = 0; redirect_i = 0; mem_req_i = 0;

        // Power-up reset, then reset abandoning an access in WAIT
        idle(0); idle(0); idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(0); idle(0); idle(1); idle(1);

        // Load-use via rs, via rt not used, via r0
        step(1, 1, 8, 8, 0, 0, 0, 0); idle(1);
        step(1, 1, 8, 0, 8, 0, 0, 0); idle(1);
        step(1, 1, 0, 0, 0, 1, 0, 0); idle(1);
        step(1, 1, 8, 0, 8, 1, 0, 0); idle(1);

        // Redirect suppressed by load-use, then applied
        step(1, 1, 5, 5, 0, 0, 1, 0);
        step(1, 0, 5, 5, 0, 0, 1, 0); idle(1);

        // Access held 3 cycles, then a back-to-back access
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1); idle(1);

        // Freeze has priority over load-use and redirect
        step(1, 1, 7, 7, 0, 0, 1, 1);
        step(1, 1, 7, 7, 0, 0, 1, 0);
        step(1, 1, 7, 7, 0, 0, 1, 0); idle(1);

        // Saturation of the stall counter
        idle(0);
        for (int i = 0; i < 20; i++) step(1, 1, 3, 3, 0, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) != 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage CPU. It generates the stall, hold, flush and bubble controls for the PC, the IF/ID stage register (its HD and flush inputs) and the ID/EX register.
- Detects load-use hazards.
- Applies branch/jump redirect flushes.
- Freezes the whole pipeline while a multi-cycle data-memory access in MEM completes, using an internal latency counter.
- Keeps saturating event counters for performance debug.

Parameters:
MEM_LAT, 3, data-memory access latency in cycles. Legal range 1..16; 1 means no freeze.
CNT_W, 16, width of each performance counter.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  destination register of the EX load
ifid_rs_i  in  5  rs field of the instruction in ID
ifid_rt_i  in  5  rt field of the instruction in ID
ifid_uses_rt_i  in  1  ID instruction reads rt as a source
redirect_i  in  1  branch taken or jump resolved in ID this cycle
mem_req_i  in  1  load/store present in MEM stage
pc_write_o  out  1  PC register load enable
ifid_hold_o  out  1  IF/ID hold (HD)
ifid_flush_o  out  1  IF/ID clear to zero
idex_bubble_o  out  1  ID/EX loads control zeros (NOP)
freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
stall_cnt_o  out  CNT_W  load-use stall cycles
freeze_cnt_o  out  CNT_W  freeze cycles
flush_cnt_o  out  CNT_W  flush cycles

Behaviour:
- Control outputs are Mealy: combinational from state and inputs, same cycle. State and counters are registered.
- Reset: rst_i low at a clock edge sets state=RUN, wait counter=0 and all three performance counters=0. While rst_i is low, all control outputs are 0, including pc_write_o. Reset mid-WAIT abandons the access countdown.
- load_use = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i))).
- FSM states:
  - RUN: normal operation.
  - WAIT: memory access in progress. Internal counter cnt has width 4.
- Freeze trigger: in RUN with mem_req_i=1 and MEM_LAT>1:
  - Outputs: freeze_o=1, pc_write_o=0, ifid_hold_o=1, ifid_flush_o=0, idex_bubble_o=0. Hazard inputs are ignored.
  - Next state: cnt<=MEM_LAT-2, state<=WAIT.
- WAIT with cnt!=0: same freeze outputs; cnt<=cnt-1.
- WAIT with cnt==0 (release cycle): freeze_o=0; normal hazard logic applies; state<=RUN. mem_req_i is not a trigger in this cycle, because the same access is completing.
- Total access = MEM_LAT cycles. freeze_o is high for the first MEM_LAT-1 of them.
- A back-to-back memory instruction retriggers in the following RUN cycle.
- Normal hazard logic (RUN without trigger, or release cycle), priority order:
  1. load_use: pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1, ifid_flush_o=0. Any redirect is suppressed because the branch operands are stale; it re-resolves next cycle.
  2. redirect_i: pc_write_o=1, ifid_flush_o=1, ifid_hold_o=0, idex_bubble_o=0.
  3. Otherwise: pc_write_o=1, all others 0.
- ifid_hold_o and ifid_flush_o are never both 1.
- Counters (only while rst_i high), each saturating at all-ones (no wrap):
  - stall_cnt_o +1 per cycle with load_use applied.
  - freeze_cnt_o +1 per cycle with freeze_o=1.
  - flush_cnt_o +1 per cycle with ifid_flush_o=1.
- MEM_LAT=1: WAIT is unreachable; freeze_o is constant 0.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles during WAIT, then release -> state RUN, all counters 0, pc_write_o=0 while in reset and 1 after.
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for 1 cycle -> pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1, stall_cnt_o=1. Repeat with ifid_rt_i=8, ifid_uses_rt_i=0 -> no stall. Repeat with idex_rt_i=0 -> no stall.
- Redirect with hazard: redirect_i=1 and load_use=1 together -> ifid_flush_o=0, stall applied. Next cycle load_use=0, redirect_i=1 -> ifid_flush_o=1, flush_cnt_o=1.
- MEM_LAT=3, mem_req_i held high 3 cycles -> freeze_o=1,1,0, freeze_cnt_o=2, no retrigger on the release cycle. A second access immediately after -> freeze_o=1 again on the next cycle.
- Freeze vs hazard: mem_req_i=1 with load_use=1 and redirect_i=1 in RUN -> freeze outputs only (flush 0, bubble 0), stall_cnt_o unchanged.
- Saturation: CNT_W=4, 20 consecutive load-use cycles -> stall_cnt_o stays 15.
